reflet_vga_txt_term: RTL
========================

# reflet_VGA_txt_term

Character-stream terminal controller that sits directly upstream of the text-mode VGA renderer. It accepts one byte at a time over a valid/ready handshake, tracks a cursor, and interprets CR/LF/BS/FF. It drives the renderer's text write port (write enable, cell coordinates, character, fg/bg colours) and clears rows and the screen itself, so software only has to push bytes.

## Interface
- h_size, 640: screen width in pixels; COLS = h_size/8/2^bit_reduction.
- v_size, 480: screen height in pixels; ROWS = v_size/8/2^bit_reduction.
- color_depth, 8: bits per colour channel.
- bit_reduction, 0: must match the downstream renderer.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- char_valid  in  1  byte offered.
- char_data  in  8  byte.
- R_fg_in/G_fg_in/B_fg_in/R_bg_in/G_bg_in/B_bg_in  in  color_depth each  colours captured with every accepted byte.
- ready  out  1  byte accepted on an edge where char_valid & ready.
- write_en  out  1  registered text write strobe to the renderer.
- h_txt_out  out  $clog2(h_size/8)-bit_reduction  cell column.
- v_txt_out  out  $clog2(v_size/8)-bit_reduction  cell row.
- char_out  out  8  character to store.
- R_fg_out/G_fg_out/B_fg_out/R_bg_out/G_bg_out/B_bg_out  out  color_depth each.
- cursor_h, cursor_v  out  same widths as h/v_txt_out  current cursor cell.

## Operation
- States: IDLE, PEND_LINE, CLR_LINE, CLR_SCREEN. ready = (state == IDLE), combinational from state.
- Latched colours: fg and bg registers load from the *_in ports on every accepted byte, including control bytes.
- Printable bytes (0x20–0x7E, 0x80–0xFF): write (cursor, byte, latched colours), then col+1. At col COLS-1: col←0, row←row+1 (ROWS-1 wraps to 0), state→PEND_LINE.
- 0x0D CR: col←0, no write.
- 0x0A LF: col←0, row←row+1 (wrapping), state→CLR_LINE.
- 0x08 BS: col←col-1 if col>0, otherwise no change. No write.
- 0x0C FF: cursor←(0,0), state→CLR_SCREEN.
- All other bytes <0x20, and 0x7F: accepted, colours latched, otherwise ignored.
- PEND_LINE: one cycle for the character write, then CLR_LINE.
- CLR_LINE: writes char 0x20 with fg = bg = latched bg colour at (c, cursor row) for c = 0..COLS-1, one per cycle, then IDLE.
- CLR_SCREEN: same fill over row-major (0,0)..(COLS-1,ROWS-1), then IDLE.
- Clears use the clear counter, not the cursor. The cursor stays at its new position.

## Timing
- Reset values: ready=0, write_en=0, all coordinate/char/colour outputs 0, cursor (0,0), latched colours 0, state CLR_SCREEN with counter 0.
- After reset release, a full-screen black clear runs for ROWS*COLS cycles, so the renderer RAM needs no reset.
- Accept at edge k. A character write is visible in cycle k+1 (write_en=1 for exactly one cycle). cursor_h/v update at edge k.
- Back-to-back printable bytes give one write per cycle at full throughput.
- LF/FF accepted at edge k: clear writes occupy cycles k+1 .. k+COLS (or k+ROWS*COLS). ready is high again from the cycle after the last clear write.
- Wrapping printable at edge k: char write in k+1, clear writes in k+2 .. k+1+COLS.
- char_valid while ready=0: not accepted. The source must hold the byte; nothing is dropped.
- When write_en=0, the data outputs hold their last values.
- Reset mid-clear or mid-write: immediate return to reset values. The full-screen clear restarts.

## Test plan
- Params h_size=64, v_size=32 (COLS=8, ROWS=4). Release reset -> ready=0 for 32 cycles, with writes at (0,0)..(7,3), char 0x20, colours 0. Then ready=1.
- Send 'A' (0x41), fg=0xFF/0/0, bg=0/0/0x10 -> next cycle write_en=1 at (0,0), char 0x41, R_fg=0xFF, B_bg=0x10. cursor=(1,0).
- Send 8 printables from col 0 -> 8 consecutive writes at cols 0..7, then 8 clear writes on row 1 using the latched bg. cursor=(0,1). ready is low for 9 cycles total.
- At row 3, send LF -> cursor (0,0), row 0 cleared in 8 cycles. Then send BS at col 0 -> cursor unchanged, no write.
- Send 'x','y', then BS, CR, 0x07 -> cursor (2,0)→(1,0)→(0,0). No writes for the control bytes.
- FF with bg=0x11 -> 32 writes of 0x20 with all bg/fg = 0x11, cursor (0,0). Assert reset at clear write #10 -> all outputs 0, and a fresh 32-cycle black clear follows.

Source files
------------

// File: rtl/reflet_vga_txt_term_if.sv
// Byte-stream and renderer write-port bundle for the text terminal controller.
// The byte source uses the master modport; the terminal controller uses the slave modport.
interface reflet_vga_txt_term_if #(
  parameter int unsigned h_size        = 640,
  parameter int unsigned v_size        = 480,
  parameter int unsigned color_depth   = 8,
  parameter int unsigned bit_reduction = 0
);
  localparam int unsigned HW = $clog2(h_size / 8) - bit_reduction;
  localparam int unsigned VW = $clog2(v_size / 8) - bit_reduction;

  logic                   char_valid;
  logic [7:0]             char_data;
  logic [color_depth-1:0] R_fg_in;
  logic [color_depth-1:0] G_fg_in;
  logic [color_depth-1:0] B_fg_in;
  logic [color_depth-1:0] R_bg_in;
  logic [color_depth-1:0] G_bg_in;
  logic [color_depth-1:0] B_bg_in;
  logic                   ready;

  logic                   write_en;
  logic [HW-1:0]          h_txt_out;
  logic [VW-1:0]          v_txt_out;
  logic [7:0]             char_out;
  logic [color_depth-1:0] R_fg_out;
  logic [color_depth-1:0] G_fg_out;
  logic [color_depth-1:0] B_fg_out;
  logic [color_depth-1:0] R_bg_out;
  logic [color_depth-1:0] G_bg_out;
  logic [color_depth-1:0] B_bg_out;
  logic [HW-1:0]          cursor_h;
  logic [VW-1:0]          cursor_v;

  modport master (
    output char_valid, char_data,
    output R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
    input  ready, write_en, h_txt_out, v_txt_out, char_out,
    input  R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
    input  cursor_h, cursor_v
  );

  modport slave (
    input  char_valid, char_data,
    input  R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
    output ready, write_en, h_txt_out, v_txt_out, char_out,
    output R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out,
    output cursor_h, cursor_v
  );
endinterface

// File: rtl/reflet_vga_txt_term.sv
// Character-stream terminal: takes bytes, tracks a cursor, handles CR/LF/BS/FF,
// and drives the text renderer's write port, including row and screen clears.
module reflet_vga_txt_term #(
  parameter int unsigned h_size        = 640,
  parameter int unsigned v_size        = 480,
  parameter int unsigned color_depth   = 8,
  parameter int unsigned bit_reduction = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  reflet_vga_txt_term_if.slave  bus
);
  localparam int unsigned COLS = (h_size / 8) >> bit_reduction;
  localparam int unsigned ROWS = (v_size / 8) >> bit_reduction;
  localparam int unsigned HW   = $clog2(h_size / 8) - bit_reduction;
  localparam int unsigned VW   = $clog2(v_size / 8) - bit_reduction;
  localparam int unsigned CD   = color_depth;
  localparam logic [HW-1:0] COL_LAST = HW'(COLS - 1);
  localparam logic [VW-1:0] ROW_LAST = VW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, PEND_LINE, CLR_LINE, CLR_SCREEN} state_e;
  typedef logic [2:0][CD-1:0] rgb_t;  // [0]=R, [1]=G, [2]=B

  state_e        state_q, state_d;
  logic [HW-1:0] col_q, col_d;
  logic [VW-1:0] row_q, row_d;
  logic [HW-1:0] clr_col_q, clr_col_d;
  logic [VW-1:0] clr_row_q, clr_row_d;
  rgb_t          fg_q, fg_d, bg_q, bg_d;
  logic          we_q, we_d;
  logic [HW-1:0] h_txt_q, h_txt_d;
  logic [VW-1:0] v_txt_q, v_txt_d;
  logic [7:0]    char_q, char_d;
  rgb_t          fg_out_q, fg_out_d, bg_out_q, bg_out_d;

  logic          ready_c;
  logic          accept;
  logic          printable;
  logic          emit_chr;
  logic          emit_clr;
  logic [VW-1:0] row_inc;
  rgb_t          fg_in, bg_in;

  assign ready_c   = (state_q == IDLE);
  assign accept    = ready_c && bus.char_valid;
  assign printable = (bus.char_data >= 8'h20) && (bus.char_data != 8'h7F);
  assign row_inc   = (row_q == ROW_LAST) ? '0 : row_q + VW'(1);
  assign fg_in     = {bus.B_fg_in, bus.G_fg_in, bus.R_fg_in};
  assign bg_in     = {bus.B_bg_in, bus.G_bg_in, bus.R_bg_in};

  // Next state, cursor, clear counter and write-port payload.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    we_d      = 1'b0;
    h_txt_d   = h_txt_q;
    v_txt_d   = v_txt_q;
    char_d    = char_q;
    fg_out_d  = fg_out_q;
    bg_out_d  = bg_out_q;
    emit_chr  = 1'b0;
    emit_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          fg_d = fg_in;
          bg_d = bg_in;
          if (printable) begin
            emit_chr = 1'b1;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              row_d   = row_inc;
              state_d = PEND_LINE;
            end else begin
              col_d = col_q + HW'(1);
            end
          end else begin
            case (bus.char_data)
              8'h0D: col_d = '0;
              8'h0A: begin
                col_d     = '0;
                row_d     = row_inc;
                clr_col_d = '0;
                clr_row_d = row_inc;
                state_d   = CLR_LINE;
                emit_clr  = 1'b1;
              end
              8'h08: begin
                if (col_q != '0) col_d = col_q - HW'(1);
              end
              8'h0C: begin
                col_d     = '0;
                row_d     = '0;
                clr_col_d = '0;
                clr_row_d = '0;
                state_d   = CLR_SCREEN;
                emit_clr  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      PEND_LINE: begin
        clr_col_d = '0;
        clr_row_d = row_q;
        state_d   = CLR_LINE;
        emit_clr  = 1'b1;
      end
      CLR_LINE, CLR_SCREEN: begin
        // The clear counter names the cell currently on the write port;
        // after reset nothing has been written yet, so emit cell (0,0) first.
        if (!we_q) begin
          emit_clr = 1'b1;
        end else if (clr_col_q != COL_LAST) begin
          clr_col_d = clr_col_q + HW'(1);
          emit_clr  = 1'b1;
        end else if ((state_q == CLR_SCREEN) && (clr_row_q != ROW_LAST)) begin
          clr_col_d = '0;
          clr_row_d = clr_row_q + VW'(1);
          emit_clr  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit_chr) begin
      we_d     = 1'b1;
      h_txt_d  = col_q;
      v_txt_d  = row_q;
      char_d   = bus.char_data;
      fg_out_d = fg_in;
      bg_out_d = bg_in;
    end

    // Clear cells are blanks painted entirely in the latched background.
    if (emit_clr) begin
      we_d     = 1'b1;
      h_txt_d  = clr_col_d;
      v_txt_d  = clr_row_d;
      char_d   = 8'h20;
      fg_out_d = bg_d;
      bg_out_d = bg_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLR_SCREEN;
      col_q     <= '0;
      row_q     <= '0;
      clr_col_q <= '0;
      clr_row_q <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      we_q      <= 1'b0;
      h_txt_q   <= '0;
      v_txt_q   <= '0;
      char_q    <= '0;
      fg_out_q  <= '0;
      bg_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      we_q      <= we_d;
      h_txt_q   <= h_txt_d;
      v_txt_q   <= v_txt_d;
      char_q    <= char_d;
      fg_out_q  <= fg_out_d;
      bg_out_q  <= bg_out_d;
    end
  end

  assign bus.ready     = ready_c;
  assign bus.write_en  = we_q;
  assign bus.h_txt_out = h_txt_q;
  assign bus.v_txt_out = v_txt_q;
  assign bus.char_out  = char_q;
  assign bus.R_fg_out  = fg_out_q[0];
  assign bus.G_fg_out  = fg_out_q[1];
  assign bus.B_fg_out  = fg_out_q[2];
  assign bus.R_bg_out  = bg_out_q[0];
  assign bus.G_bg_out  = bg_out_q[1];
  assign bus.B_bg_out  = bg_out_q[2];
  assign bus.cursor_h  = col_q;
  assign bus.cursor_v  = row_q;
endmodule
